// File: rtl/param_wb_sched_pkg.sv
// param_wb_sched_pkg -- shared definitions for the weight/bias parameter
// load scheduler.
//   `BIT_DATA / `BIT_PSUM : datapath word widths (overridable on the command line)
//   wb_state_e            : scheduler FSM states
//   RD_LAT                : cycles from read issue to emitted parameter word
//   BIAS_WORDS            : extra words fetched per column (1 when PARAM_WB_BIAS_EN)
//   idx_w()               : index width helper (never below 1 bit)
`ifndef BIT_DATA
`define BIT_DATA 16
`endif
`ifndef BIT_PSUM
`define BIT_PSUM 32
`endif

package param_wb_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } wb_state_e;

   // Issue in cycle T, buffer data in T+1, registered word out in T+2.
   localparam int unsigned RD_LAT = 2;

`ifdef PARAM_WB_BIAS_EN
   localparam int unsigned BIAS_WORDS = 1;
`else
   localparam int unsigned BIAS_WORDS = 0;
`endif

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/param_wb_sched_addr_gen.sv
// param_wb_addr_gen -- column-major row/column/address counters for the
// parameter load scheduler.
//   i_Clk, i_Rstn : clock, asynchronous active-low reset
//   i_Clear       : synchronous restart at row 0 / column 0 / offset 0
//   i_Advance     : step to the next word (one read issued this cycle)
//   i_Base        : load base address; o_Addr = i_Base + words issued
//   o_Addr        : current read address, wraps modulo 2^ADDR_W
//   o_Col, o_Row  : current column / row index (row NUM_ROW is the bias word)
//   o_Last        : current word is the final word of the load
module param_wb_addr_gen
   import param_wb_sched_pkg::*;
#(
   parameter  int unsigned NUM_ROW = 16,
   parameter  int unsigned NUM_COL = 16,
   parameter  int unsigned ADDR_W  = 12,
   localparam int unsigned ROWS    = NUM_ROW + BIAS_WORDS,
   localparam int unsigned ROW_W   = idx_w(ROWS),
   localparam int unsigned COL_W   = idx_w(NUM_COL)
)(
   input  logic              i_Clk,
   input  logic              i_Rstn,
   input  logic              i_Clear,
   input  logic              i_Advance,
   input  logic [ADDR_W-1:0] i_Base,
   output logic [ADDR_W-1:0] o_Addr,
   output logic [COL_W-1:0]  o_Col,
   output logic [ROW_W-1:0]  o_Row,
   output logic              o_Last
);

   logic [ADDR_W-1:0] r_Count;
   logic [COL_W-1:0]  r_Col;
   logic [ROW_W-1:0]  r_Row;
   logic              w_Row_End;
   logic              w_Col_End;

   assign w_Row_End = (r_Row == ROW_W'(ROWS - 1));
   assign w_Col_End = (r_Col == COL_W'(NUM_COL - 1));

   always_ff @(posedge i_Clk or negedge i_Rstn) begin
      if (!i_Rstn) begin
         r_Count <= '0;
         r_Col   <= '0;
         r_Row   <= '0;
      end else if (i_Clear) begin
         r_Count <= '0;
         r_Col   <= '0;
         r_Row   <= '0;
      end else if (i_Advance) begin
         r_Count <= r_Count + ADDR_W'(1);
         if (w_Row_End) begin
            r_Row <= '0;
            r_Col <= w_Col_End ? '0 : r_Col + COL_W'(1);
         end else begin
            r_Row <= r_Row + ROW_W'(1);
         end
      end
   end

   assign o_Addr = i_Base + r_Count;
   assign o_Col  = r_Col;
   assign o_Row  = r_Row;
   assign o_Last = w_Row_End & w_Col_End;

endmodule

// File: rtl/param_wb_sched.sv
// param_wb_sched -- fetches NUM_ROW x NUM_COL weight words (column-major)
// from a parameter buffer and streams them to the weight/bias cells with a
// one-hot column select. Optional macro PARAM_WB_BIAS_EN appends one bias
// word per column and adds the o_Bias_Flag output.
//   CLK, RSTn         : clock, asynchronous active-low reset
//   i_Start           : load request (IDLE only), samples i_Base_Addr
//   i_Clear           : synchronous abort, highest priority
//   i_Stall           : suppresses new reads; in-flight words still emerge
//   o_Rd_En/o_Rd_Addr : buffer read strobe/address; i_Rd_Data one cycle later
//   o_Param_WB        : parameter word, qualified by o_Valid_WB_Param
//   o_Col_Sel         : one-hot target column (zero when not valid)
//   o_Busy, o_Done    : not-IDLE flag, one-cycle completion pulse
//   o_Bias_Flag       : (PARAM_WB_BIAS_EN only) current word is a bias
`ifndef BIT_DATA
`define BIT_DATA 16
`endif

module param_wb_sched
   import param_wb_sched_pkg::*;
#(
   parameter int unsigned NUM_ROW = 16,
   parameter int unsigned NUM_COL = 16,
   parameter int unsigned ADDR_W  = 12
)(
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic                 i_Start,
   input  logic [ADDR_W-1:0]    i_Base_Addr,
   input  logic                 i_Clear,
   input  logic                 i_Stall,
   output logic                 o_Rd_En,
   output logic [ADDR_W-1:0]    o_Rd_Addr,
   input  logic [`BIT_DATA-1:0] i_Rd_Data,
   output logic [`BIT_DATA-1:0] o_Param_WB,
   output logic                 o_Valid_WB_Param,
   output logic [NUM_COL-1:0]   o_Col_Sel,
   output logic                 o_Busy,
   output logic                 o_Done
`ifdef PARAM_WB_BIAS_EN
  ,output logic                 o_Bias_Flag
`endif
);

   localparam int unsigned ROWS  = NUM_ROW + BIAS_WORDS;
   localparam int unsigned ROW_W = idx_w(ROWS);
   localparam int unsigned COL_W = idx_w(NUM_COL);
   localparam int unsigned PIPE  = RD_LAT - 1;   // sideband stages before data capture

   wb_state_e r_State, w_Next;

   logic [ADDR_W-1:0] r_Base;
   logic [ADDR_W-1:0] w_Addr;
   logic [COL_W-1:0]  w_Col;
   logic [ROW_W-1:0]  w_Row;
   logic              w_Last;
   logic              w_Issue;
   logic              w_Load;
   logic              w_Is_Bias;

   // Sideband travelling with each read until its data returns.
   logic              r_Pipe_V    [PIPE];
   logic [COL_W-1:0]  r_Pipe_Col  [PIPE];
   logic              r_Pipe_Last [PIPE];
   logic              r_Pipe_Bias [PIPE];

   logic                 r_Valid;
   logic [`BIT_DATA-1:0] r_Data;
   logic [NUM_COL-1:0]   r_Col_Sel;
   logic                 r_Last_Out;
   logic                 r_Bias;

   assign w_Issue = (r_State == ST_FETCH) && !i_Stall && !i_Clear;
   assign w_Load  = (r_State == ST_IDLE)  && i_Start && !i_Clear;

   param_wb_addr_gen #(
      .NUM_ROW (NUM_ROW),
      .NUM_COL (NUM_COL),
      .ADDR_W  (ADDR_W)
   ) u_addr_gen (
      .i_Clk     (CLK),
      .i_Rstn    (RSTn),
      .i_Clear   (i_Clear | w_Load),
      .i_Advance (w_Issue),
      .i_Base    (r_Base),
      .o_Addr    (w_Addr),
      .o_Col     (w_Col),
      .o_Row     (w_Row),
      .o_Last    (w_Last)
   );

`ifdef PARAM_WB_BIAS_EN
   assign w_Is_Bias   = (w_Row == ROW_W'(NUM_ROW));
   assign o_Bias_Flag = r_Bias;
`else
   // Row index and bias path only matter when bias words are fetched.
   logic w_unused_bias;
   assign w_Is_Bias     = 1'b0;
   assign w_unused_bias = r_Bias ^ (^w_Row);
`endif

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_Base <= '0;
      end else if (i_Clear) begin
         r_Base <= '0;
      end else if (w_Load) begin
         r_Base <= i_Base_Addr;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_State <= ST_IDLE;
      end else begin
         r_State <= w_Next;
      end
   end

   always_comb begin
      w_Next    = r_State;
      o_Rd_En   = w_Issue;
      o_Rd_Addr = w_Issue ? w_Addr : '0;
      o_Busy    = (r_State != ST_IDLE);
      o_Done    = (r_State == ST_DONE);
      if (i_Clear) begin
         w_Next = ST_IDLE;
      end else begin
         unique case (r_State)
            ST_IDLE:  if (i_Start) w_Next = ST_FETCH;
            ST_FETCH: if (w_Issue && w_Last) w_Next = ST_DRAIN;
            ST_DRAIN: if (r_Last_Out) w_Next = ST_DONE;
            ST_DONE:  w_Next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int unsigned i = 0; i < PIPE; i++) begin
            r_Pipe_V[i]    <= 1'b0;
            r_Pipe_Col[i]  <= '0;
            r_Pipe_Last[i] <= 1'b0;
            r_Pipe_Bias[i] <= 1'b0;
         end
         r_Valid    <= 1'b0;
         r_Data     <= '0;
         r_Col_Sel  <= '0;
         r_Last_Out <= 1'b0;
         r_Bias     <= 1'b0;
      end else if (i_Clear) begin
         for (int unsigned i = 0; i < PIPE; i++) begin
            r_Pipe_V[i]    <= 1'b0;
            r_Pipe_Col[i]  <= '0;
            r_Pipe_Last[i] <= 1'b0;
            r_Pipe_Bias[i] <= 1'b0;
         end
         r_Valid    <= 1'b0;
         r_Data     <= '0;
         r_Col_Sel  <= '0;
         r_Last_Out <= 1'b0;
         r_Bias     <= 1'b0;
      end else begin
         r_Pipe_V[0]    <= w_Issue;
         r_Pipe_Col[0]  <= w_Issue ? w_Col : '0;
         r_Pipe_Last[0] <= w_Issue & w_Last;
         r_Pipe_Bias[0] <= w_Issue & w_Is_Bias;
         for (int unsigned i = 1; i < PIPE; i++) begin
            r_Pipe_V[i]    <= r_Pipe_V[i-1];
            r_Pipe_Col[i]  <= r_Pipe_Col[i-1];
            r_Pipe_Last[i] <= r_Pipe_Last[i-1];
            r_Pipe_Bias[i] <= r_Pipe_Bias[i-1];
         end
         // Buffer data is valid in the cycle after the read, i.e. when the
         // sideband reaches the last stage.
         r_Valid    <= r_Pipe_V[PIPE-1];
         r_Data     <= r_Pipe_V[PIPE-1] ? i_Rd_Data : '0;
         r_Col_Sel  <= r_Pipe_V[PIPE-1] ? (NUM_COL'(1) << r_Pipe_Col[PIPE-1]) : '0;
         r_Last_Out <= r_Pipe_Last[PIPE-1];
         r_Bias     <= r_Pipe_Bias[PIPE-1];
      end
   end

   assign o_Valid_WB_Param = r_Valid;
   assign o_Param_WB       = r_Data;
   assign o_Col_Sel        = r_Col_Sel;

endmodule

// File: tb/tb_param_wb_sched.sv
// tb_param_wb_sched -- self-checking bench for param_wb_sched (4x4, ADDR_W=12).
// A transaction-level model (issue counter + queue of expected emissions)
// predicts every output each cycle; literal checks pin the directed scenarios.
// Works with and without PARAM_WB_BIAS_EN.
`ifndef BIT_DATA
`define BIT_DATA 16
`endif

module tb_param_wb_sched;

   localparam int unsigned NR = 4;
   localparam int unsigned NC = 4;
   localparam int unsigned AW = 12;
   localparam int unsigned DW = `BIT_DATA;
`ifdef PARAM_WB_BIAS_EN
   localparam int unsigned BW        = 1;
   localparam int          EXP_WORDS = 20;
   localparam logic [63:0] EXP_LAST  = 64'h0023;
`else
   localparam int unsigned BW        = 0;
   localparam int          EXP_WORDS = 16;
   localparam logic [63:0] EXP_LAST  = 64'h001F;
`endif
   localparam int unsigned RPC   = NR + BW;
   localparam int          TOTAL = int'(NC * RPC);

   logic          CLK = 1'b0;
   logic          RSTn = 1'b0;
   logic          i_Start = 1'b0;
   logic          i_Clear = 1'b0;
   logic          i_Stall = 1'b0;
   logic [AW-1:0] i_Base_Addr = '0;
   logic [DW-1:0] i_Rd_Data = '0;
   logic          o_Rd_En;
   logic [AW-1:0] o_Rd_Addr;
   logic [DW-1:0] o_Param_WB;
   logic          o_Valid_WB_Param;
   logic [NC-1:0] o_Col_Sel;
   logic          o_Busy;
   logic          o_Done;
`ifdef PARAM_WB_BIAS_EN
   logic          o_Bias_Flag;
`endif

   param_wb_sched #(.NUM_ROW(NR), .NUM_COL(NC), .ADDR_W(AW)) dut (
      .CLK              (CLK),
      .RSTn             (RSTn),
      .i_Start          (i_Start),
      .i_Base_Addr      (i_Base_Addr),
      .i_Clear          (i_Clear),
      .i_Stall          (i_Stall),
      .o_Rd_En          (o_Rd_En),
      .o_Rd_Addr        (o_Rd_Addr),
      .i_Rd_Data        (i_Rd_Data),
      .o_Param_WB       (o_Param_WB),
      .o_Valid_WB_Param (o_Valid_WB_Param),
      .o_Col_Sel        (o_Col_Sel),
      .o_Busy           (o_Busy),
      .o_Done           (o_Done)
`ifdef PARAM_WB_BIAS_EN
     ,.o_Bias_Flag      (o_Bias_Flag)
`endif
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Buffer contents: address xor a per-test salt (salt 0 => word = address).
   logic [DW-1:0] salt = '0;
   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a, input logic [DW-1:0] s);
      return DW'(a) ^ s;
   endfunction

   initial begin : buffer_model
      logic          p;
      logic [AW-1:0] a;
      forever begin
         @(negedge CLK);
         p = o_Rd_En;
         a = o_Rd_Addr;
         @(posedge CLK);
         #1;
         i_Rd_Data = p ? mem_word(a, salt) : DW'($urandom);
      end
   end

   // ---------------- reference model + per-cycle compare ----------------
   typedef struct {
      int            cyc;
      logic [DW-1:0] data;
      int            col;
      bit            bias;
   } emit_t;

   emit_t         mq[$];
   bit            m_busy = 1'b0;
   int            m_next = 0;
   int            m_done_cyc = -1;
   logic [AW-1:0] m_base = '0;
   logic [AW-1:0] m_addr_log[$];

   logic [DW-1:0] obs_data[$];
   int            obs_cyc[$];
   logic [NC-1:0] obs_col[$];
   bit            obs_bias[$];
   int            obs_done = 0;
   int            obs_done_cyc = -1;

   initial begin : model
      bit            exp_rd, exp_v, idle_now;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_d;
      logic [NC-1:0] exp_cs;
      bit            exp_b;
      emit_t         e;
      forever begin
         @(negedge CLK);
         cyc++;
         if (o_Valid_WB_Param) begin
            obs_data.push_back(o_Param_WB);
            obs_cyc.push_back(cyc);
            obs_col.push_back(o_Col_Sel);
`ifdef PARAM_WB_BIAS_EN
            obs_bias.push_back(o_Bias_Flag);
`else
            obs_bias.push_back(1'b0);
`endif
         end
         if (o_Done) begin
            obs_done++;
            obs_done_cyc = cyc;
         end
         if (!RSTn) begin
            chk("rst_rd_en", o_Rd_En, 0);
            chk("rst_rd_addr", o_Rd_Addr, 0);
            chk("rst_valid", o_Valid_WB_Param, 0);
            chk("rst_param", o_Param_WB, 0);
            chk("rst_col_sel", o_Col_Sel, 0);
            chk("rst_busy", o_Busy, 0);
            chk("rst_done", o_Done, 0);
            m_busy = 1'b0; m_next = 0; m_done_cyc = -1; mq.delete();
            continue;
         end
         exp_rd   = m_busy && (m_next < TOTAL) && !i_Stall && !i_Clear;
         exp_addr = exp_rd ? m_base + AW'(m_next) : '0;
         exp_v = 1'b0; exp_d = '0; exp_cs = '0; exp_b = 1'b0;
         if (mq.size() > 0 && mq[0].cyc == cyc) begin
            e = mq.pop_front();
            exp_v  = 1'b1;
            exp_d  = e.data;
            exp_cs = NC'(1) << e.col;
            exp_b  = e.bias;
         end
         chk("rd_en", o_Rd_En, exp_rd);
         chk("rd_addr", o_Rd_Addr, exp_addr);
         chk("valid", o_Valid_WB_Param, exp_v);
         chk("param", o_Param_WB, exp_d);
         chk("col_sel", o_Col_Sel, exp_cs);
         chk("busy", o_Busy, m_busy);
         chk("done", o_Done, cyc == m_done_cyc);
`ifdef PARAM_WB_BIAS_EN
         chk("bias_flag", o_Bias_Flag, exp_b);
`endif
         // advance the model across the coming clock edge
         if (i_Clear) begin
            m_busy = 1'b0; m_next = 0; m_done_cyc = -1; mq.delete();
         end else begin
            idle_now = !m_busy;
            if (exp_rd) begin
               e.cyc  = cyc + 2;
               e.data = mem_word(exp_addr, salt);
               e.col  = m_next / int'(RPC);
               e.bias = (m_next % int'(RPC)) == int'(NR);
               mq.push_back(e);
               m_addr_log.push_back(exp_addr);
               if (m_next == TOTAL - 1) m_done_cyc = cyc + 3;
               m_next++;
            end
            if (cyc == m_done_cyc) begin
               m_busy = 1'b0;
               m_done_cyc = -1;
            end
            if (idle_now && i_Start) begin
               m_busy = 1'b1;
               m_next = 0;
               m_base = i_Base_Addr;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic start_load(input logic [AW-1:0] base);
      i_Base_Addr = base;
      i_Start = 1'b1;
      tick();
      i_Start = 1'b0;
      i_Base_Addr = AW'($urandom);
   endtask

   task automatic run_until_done(input string name, input int stall_mod);
      int n = 0;
      while (!o_Done && n < 300) begin
         i_Stall = (stall_mod != 0) && ($urandom_range(stall_mod - 1) == 0);
         tick();
         n++;
      end
      i_Stall = 1'b0;
      chk(name, o_Done, 1);
      tick();
      tick();
   endtask

   task automatic reset_logs();
      obs_data.delete(); obs_cyc.delete(); obs_col.delete(); obs_bias.delete();
      m_addr_log.delete();
      obs_done = 0;
      obs_done_cyc = -1;
   endtask

   initial begin : stim
      int clr_cyc, late;
      repeat (3) tick();
      chk("por_busy", o_Busy, 0);
      chk("por_valid", o_Valid_WB_Param, 0);

      // Basic load, start on the first edge after reset release.
      RSTn = 1'b1;
      reset_logs();
      start_load(12'h010);
      run_until_done("t1_timeout", 0);
      chk("t1_count", obs_data.size(), EXP_WORDS);
      chk("t1_first", obs_data[0], 64'h0010);
      chk("t1_last", obs_data[EXP_WORDS-1], EXP_LAST);
      chk("t1_col0", obs_col[0], 4'b0001);
      chk("t1_contig", obs_cyc[EXP_WORDS-1] - obs_cyc[0], EXP_WORDS - 1);
      chk("t1_done_lat", obs_done_cyc - obs_cyc[EXP_WORDS-1], 1);
      chk("t1_done_cnt", obs_done, 1);
`ifdef PARAM_WB_BIAS_EN
      chk("t1_col_w4", obs_col[4], 4'b0001);
      chk("t1_bias4", obs_bias[4], 1);
      chk("t1_bias9", obs_bias[9], 1);
      chk("t1_bias14", obs_bias[14], 1);
      chk("t1_bias19", obs_bias[19], 1);
      chk("t1_col_w9", obs_col[9], 4'b0010);
      chk("t1_col_w19", obs_col[19], 4'b1000);
      chk("t1_bias3", obs_bias[3], 0);
`else
      chk("t1_col_w4", obs_col[4], 4'b0010);
      chk("t1_col_w15", obs_col[15], 4'b1000);
`endif

      // Three-cycle stall in column 1.
      reset_logs();
      start_load(12'h010);
      repeat (6) tick();
      i_Stall = 1'b1;
      repeat (3) tick();
      i_Stall = 1'b0;
      run_until_done("t2_timeout", 0);
      chk("t2_count", obs_data.size(), EXP_WORDS);
      for (int k = 0; k < EXP_WORDS; k++) chk("t2_seq", obs_data[k], 64'h0010 + 64'(k));
      chk("t2_gap", obs_cyc[6] - obs_cyc[5], 4);
      chk("t2_nogap", obs_cyc[5] - obs_cyc[4], 1);

      // Address wrap with random stalls and scrambled buffer contents.
      reset_logs();
      salt = DW'($urandom);
      start_load(12'hFFE);
      run_until_done("t3_timeout", 3);
      chk("t3_addr0", m_addr_log[0], 12'hFFE);
      chk("t3_addr1", m_addr_log[1], 12'hFFF);
      chk("t3_addr2", m_addr_log[2], 12'h000);
      chk("t3_count", obs_data.size(), EXP_WORDS);
      salt = '0;

      // Clear at word 7, then a fresh load.
      reset_logs();
      start_load(12'h010);
      repeat (7) tick();
      i_Clear = 1'b1;
      clr_cyc = cyc + 1;
      tick();
      i_Clear = 1'b0;
      repeat (8) tick();
      late = 0;
      foreach (obs_cyc[k]) if (obs_cyc[k] > clr_cyc) late++;
      chk("t4_no_late_valid", late, 0);
      chk("t4_words_before", obs_data.size(), 6);
      chk("t4_no_done", obs_done, 0);
      chk("t4_idle", o_Busy, 0);
      reset_logs();
      start_load(12'h010);
      run_until_done("t4b_timeout", 0);
      chk("t4b_first", obs_data[0], 64'h0010);
      chk("t4b_count", obs_data.size(), EXP_WORDS);

      // Reset at word 5; then a second start while busy is ignored.
      reset_logs();
      start_load(12'h010);
      repeat (5) tick();
      RSTn = 1'b0;
      #1;
      chk("t5_rst_busy", o_Busy, 0);
      chk("t5_rst_rd_en", o_Rd_En, 0);
      chk("t5_rst_valid", o_Valid_WB_Param, 0);
      chk("t5_rst_col", o_Col_Sel, 0);
      tick();
      tick();
      RSTn = 1'b1;
      repeat (10) tick();
      chk("t5_no_done", obs_done, 0);
      reset_logs();
      start_load(12'h010);
      repeat (4) tick();
      start_load(12'h300);
      run_until_done("t5b_timeout", 0);
      chk("t5b_count", obs_data.size(), EXP_WORDS);
      chk("t5b_last", obs_data[EXP_WORDS-1], EXP_LAST);
      chk("t5b_done_cnt", obs_done, 1);

      // Random mix checked by the model alone.
      for (int n = 0; n < 1500; n++) begin
         if (!o_Busy && $urandom_range(7) == 0) salt = DW'($urandom);
         i_Base_Addr = AW'($urandom);
         i_Start = ($urandom_range(7) == 0);
         i_Stall = ($urandom_range(2) == 0);
         i_Clear = ($urandom_range(59) == 0);
         tick();
      end
      i_Start = 1'b0; i_Stall = 1'b0; i_Clear = 1'b0;
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
